col_window_gen: RTL

- Consumes the padded 26-row column stream produced by the input pre-data stage: one 208-bit column per PE clock while the upstream valid is high.
- Keeps a sliding window of the last KSIZE columns and presents a KSIZE x ROWS window to the PE array on every new column once the window is full.
- Tracks frame position and flags short or aborted frames.
- Sits directly downstream of the pre-data stage, in the PE clock domain.

---
 rtl/pe_pkg.sv | 9 +
 rtl/col_shift_reg.sv | 21 ++
 rtl/col_window_gen.sv | 77 +++++++
 3 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared frame geometry constants and window FSM state type for the PE input path
package pe_pkg;
  localparam int PAD_ROWS = 26;
  localparam int PAD_COLS = 34;
  localparam int KSIZE = 3;
  localparam int PIX_W = 8;
  localparam int COL_W = PAD_ROWS * PIX_W;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;
endpackage

// File: rtl/col_shift_reg.sv
// col_shift_reg: DEPTH-deep W-wide column shift register (clk, rst_n, shift, clr, din in; dout out, oldest column in MSB slice)
module col_shift_reg
  import pe_pkg::*;
#(
  parameter int DEPTH = KSIZE,
  parameter int W = COL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift,
  input  logic               clr,
  input  logic [W-1:0]       din,
  output logic [DEPTH*W-1:0] dout
);
  logic [DEPTH*W-1:0] data_q, data_d;
  always_comb data_d = clr ? '0 : shift ? {data_q[(DEPTH-1)*W-1:0], din} : data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
  assign dout = data_q;
endmodule

// File: rtl/col_window_gen.sv
// col_window_gen: sliding KSIZE-column window over a padded column stream (clk, rst_n, en, in_col, in_vld in; win_data, win_vld, win_col, frame_done, frame_err out)
module col_window_gen #(
  parameter int ROWS = pe_pkg::PAD_ROWS,
  parameter int COLS = pe_pkg::PAD_COLS,
  parameter int KSIZE = pe_pkg::KSIZE,
  parameter int DW = pe_pkg::PIX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ROWS*DW-1:0]       in_col,
  input  logic                     in_vld,
  output logic [KSIZE*ROWS*DW-1:0] win_data,
  output logic                     win_vld,
  output logic [5:0]               win_col,
  output logic                     frame_done,
  output logic                     frame_err
);
  import pe_pkg::*;
  localparam logic [5:0] KS = 6'(KSIZE);
  localparam logic [5:0] CN = 6'(COLS);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, cnt_inc;
  logic win_vld_q, win_vld_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
  logic shift, clr;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cnt_inc = cnt_q + 6'd1;
    win_vld_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d = 1'b0;
    shift = 1'b0;
    clr = 1'b0;
    if (en) begin
      if (in_vld && state_q != DRAIN) begin
        shift = 1'b1;
        cnt_d = cnt_inc;
        win_vld_d = cnt_inc >= KS;
        frame_done_d = cnt_inc == CN;
        state_d = cnt_inc == CN ? DRAIN : cnt_inc >= KS ? STREAM : FILL;
      end else if (!in_vld && state_q != IDLE) begin
        // a drop before DRAIN means the frame was short
        state_d = IDLE;
        cnt_d = '0;
        frame_err_d = state_q != DRAIN;
        clr = state_q != DRAIN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      win_vld_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      win_vld_q <= win_vld_d;
      frame_done_q <= frame_done_d;
      frame_err_q <= frame_err_d;
    end
  col_shift_reg #(.DEPTH(KSIZE), .W(ROWS*DW)) u_shift (
    .clk(clk),
    .rst_n(rst_n),
    .shift(shift),
    .clr(clr),
    .din(in_col),
    .dout(win_data)
  );
  assign win_vld = win_vld_q;
  assign win_col = win_vld_q ? cnt_q - KS : '0;
  assign frame_done = frame_done_q;
  assign frame_err = frame_err_q;
endmodule
